// File: rtl/pll_seq_pkg.sv
// Shared types for the PLL lock sequencer: FSM state encoding and the
// width of the saturating lock-loss counter.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RESET     = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  localparam int LOST_W = 8;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer; both stages clear to 0 on asynchronous
// active-low reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Brings up an SB_PLL40_CORE: pulses RESETB, waits for a stable LOCK with
// timeout and bounded retries, then releases the downstream reset.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int  RESET_CYCLES  = 16,
  parameter int  LOCK_TIMEOUT  = 12000,
  parameter int  STABLE_CYCLES = 1024,
  parameter int  MAX_RETRIES   = 3,
  localparam int RC_W          = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic              clock_in,
  input  logic              reset_n,
  input  logic              pll_locked,
  input  logic              restart,
  output logic              pll_resetb,
  output logic              sys_reset_n,
  output logic              ready,
  output logic              fault,
  output logic [RC_W-1:0]   retry_count,
  output logic [LOST_W-1:0] lock_lost_count
);

  localparam int CNT_MAX_RT = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX    = (CNT_MAX_RT > STABLE_CYCLES) ? CNT_MAX_RT : STABLE_CYCLES;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]  RST_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  STB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [RC_W-1:0]   RC_MAX   = RC_W'(MAX_RETRIES);
  localparam logic [RC_W-1:0]   RC_ONE   = RC_W'(1);
  localparam logic [LOST_W-1:0] LOST_ONE = LOST_W'(1);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [RC_W-1:0]    r_retry, w_retry_nxt;
  logic [LOST_W-1:0]  r_lost, w_lost_nxt;
  logic               r_pll_resetb, r_sys_reset_n, r_ready, r_fault;
  logic               w_locked_s;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .i_clk   (clock_in),
    .i_rst_n (reset_n),
    .i_d     (pll_locked),
    .o_q     (w_locked_s)
  );

  // One shared counter: it is cleared on every state entry, so each state
  // measures its own dwell time against its own terminal value.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_retry_nxt = r_retry;
    w_lost_nxt  = r_lost;
    if (restart) begin
      w_state_nxt = RESET;
      w_cnt_nxt   = '0;
      w_retry_nxt = '0;
    end else begin
      case (r_state)
        RESET: begin
          if (r_cnt == RST_LAST) begin
            w_state_nxt = WAIT_LOCK;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        WAIT_LOCK: begin
          // Lock seen on the timeout cycle still wins.
          if (w_locked_s) begin
            w_state_nxt = STABLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == TO_LAST) begin
            w_cnt_nxt = '0;
            if (r_retry == RC_MAX) begin
              w_state_nxt = FAULT;
            end else begin
              w_state_nxt = RESET;
              w_retry_nxt = r_retry + RC_ONE;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        STABLE: begin
          if (!w_locked_s) begin
            w_state_nxt = WAIT_LOCK;
            w_cnt_nxt   = '0;
          end else if (r_cnt == STB_LAST) begin
            w_state_nxt = RUN;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        RUN: begin
          if (!w_locked_s) begin
            w_state_nxt = RESET;
            w_cnt_nxt   = '0;
            w_retry_nxt = '0;
            w_lost_nxt  = (r_lost == '1) ? r_lost : r_lost + LOST_ONE;
          end
        end
        FAULT: begin
          w_state_nxt = FAULT;
        end
        default: begin
          w_state_nxt = RESET;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they move on the same edge.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= RESET;
      r_cnt         <= '0;
      r_retry       <= '0;
      r_lost        <= '0;
      r_pll_resetb  <= 1'b0;
      r_sys_reset_n <= 1'b0;
      r_ready       <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_retry       <= w_retry_nxt;
      r_lost        <= w_lost_nxt;
      r_pll_resetb  <= (w_state_nxt == WAIT_LOCK) || (w_state_nxt == STABLE) ||
                       (w_state_nxt == RUN);
      r_sys_reset_n <= (w_state_nxt == RUN);
      r_ready       <= (w_state_nxt == RUN);
      r_fault       <= (w_state_nxt == FAULT);
    end
  end

  assign pll_resetb      = r_pll_resetb;
  assign sys_reset_n     = r_sys_reset_n;
  assign ready           = r_ready;
  assign fault           = r_fault;
  assign retry_count     = r_retry;
  assign lock_lost_count = r_lost;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed bring-up/fault/boundary scenarios
// plus random lock/restart traffic, scored against a phase-timing model.
module tb_pll_lock_sequencer;

  localparam int RC = 4;
  localparam int TO = 20;
  localparam int SC = 8;
  localparam int MR = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       pll_locked = 1'b0;
  logic       restart = 1'b0;
  logic       pll_resetb, sys_reset_n, ready, fault;
  logic [1:0] retry_count;
  logic [7:0] lock_lost_count;
  logic [13:0] dut_vec;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          cyc;
    logic [13:0] vec;
  } exp_t;
  exp_t exp_q[$];

  typedef enum {M_RST, M_WAIT, M_STAB, M_RUN, M_FLT} mph_t;
  mph_t        ph = M_RST;
  int          entered = 0;
  int          m_retry = 0;
  int          m_lost = 0;
  logic        m1 = 1'b0;
  logic        m2 = 1'b0;
  logic [13:0] m_prev = '0;

  pll_lock_sequencer #(
    .RESET_CYCLES  (RC),
    .LOCK_TIMEOUT  (TO),
    .STABLE_CYCLES (SC),
    .MAX_RETRIES   (MR)
  ) dut (
    .clock_in        (clk),
    .reset_n         (reset_n),
    .pll_locked      (pll_locked),
    .restart         (restart),
    .pll_resetb      (pll_resetb),
    .sys_reset_n     (sys_reset_n),
    .ready           (ready),
    .fault           (fault),
    .retry_count     (retry_count),
    .lock_lost_count (lock_lost_count)
  );

  assign dut_vec = {pll_resetb, sys_reset_n, ready, fault, retry_count, lock_lost_count};

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: cycle %0d reached, required finish earlier", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic logic [13:0] model_vec();
    logic on, run;
    on  = (ph == M_WAIT) || (ph == M_STAB) || (ph == M_RUN);
    run = (ph == M_RUN);
    return {on, run, run, ph == M_FLT, 2'(m_retry), 8'(m_lost)};
  endfunction

  task automatic publish();
    logic [13:0] v;
    exp_t        e;
    v = model_vec();
    if (v !== m_prev) begin
      if (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc == cyc) begin
        e = exp_q.pop_back();
        e.vec = v;
        exp_q.push_back(e);
      end else begin
        e.cyc = cyc;
        e.vec = v;
        exp_q.push_back(e);
      end
      m_prev = v;
    end
  endtask

  task automatic enter(input mph_t p);
    ph = p;
    entered = cyc;
  endtask

  // Model step for the edge that just occurred; lk/rs are the inputs the DUT
  // sampled at it. The FSM sees lock as sampled two edges earlier.
  task automatic model_edge(input logic lk, input logic rs);
    logic ls;
    int   el;
    ls = m2;
    m2 = m1;
    m1 = lk;
    el = cyc - entered;
    if (rs) begin
      m_retry = 0;
      enter(M_RST);
    end else begin
      case (ph)
        M_RST:  if (el == RC) enter(M_WAIT);
        M_WAIT: begin
          if (ls) enter(M_STAB);
          else if (el == TO) begin
            if (m_retry == MR) enter(M_FLT);
            else begin
              m_retry++;
              enter(M_RST);
            end
          end
        end
        M_STAB: begin
          if (!ls) enter(M_WAIT);
          else if (el == SC) enter(M_RUN);
        end
        M_RUN: begin
          if (!ls) begin
            m_lost = (m_lost < 255) ? m_lost + 1 : 255;
            m_retry = 0;
            enter(M_RST);
          end
        end
        default: ;
      endcase
    end
    publish();
  endtask

  task automatic drive(input logic lk, input logic rs, input int n);
    for (int i = 0; i < n; i++) begin
      pll_locked = lk;
      restart = rs;
      @(posedge clk);
      #1;
      model_edge(lk, rs);
    end
    restart = 1'b0;
  endtask

  // Called at 1 time unit after a rising edge; returns the same way.
  task automatic do_reset(input int n);
    reset_n = 1'b0;
    ph = M_RST;
    entered = cyc;
    m_retry = 0;
    m_lost = 0;
    m1 = 1'b0;
    m2 = 1'b0;
    publish();
    #1;
    chk("rst_pll_resetb", int'(pll_resetb), 0);
    chk("rst_flags", int'({sys_reset_n, ready, fault}), 0);
    chk("rst_retry", int'(retry_count), 0);
    chk("rst_lost", int'(lock_lost_count), 0);
    repeat (n) @(posedge clk);
    #1;
    reset_n = 1'b1;
    entered = cyc;
  endtask

  initial begin : monitor
    logic [13:0] mon_prev;
    exp_t        e;
    mon_prev = '0;
    forever begin
      @(negedge clk);
      if (dut_vec !== mon_prev || (exp_q.size() > 0 && exp_q[0].cyc <= cyc)) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL scoreboard: outputs %h at cycle %0d, no change required", dut_vec, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.vec !== dut_vec || e.cyc != cyc) begin
            n_bad++;
            $display("FAIL scoreboard: got %h at cycle %0d, required %h at cycle %0d",
                     dut_vec, cyc, e.vec, e.cyc);
          end
        end
        mon_prev = dut_vec;
      end
    end
  end

  initial begin : stim
    logic lk;
    int   len;
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1;
    do_reset(2);

    // clean bring-up
    drive(0, 0, 3);   chk("bringup_resetb_low", int'(pll_resetb), 0);
    drive(0, 0, 1);   chk("bringup_resetb_rise", int'(pll_resetb), 1);
    drive(0, 0, 10);
    drive(1, 0, 10);  chk("bringup_before_release", int'(sys_reset_n), 0);
    drive(1, 0, 1);   chk("bringup_release", int'(sys_reset_n), 1);
    chk("bringup_ready", int'(ready), 1);
    chk("bringup_retry", int'(retry_count), 0);

    // lock loss in RUN
    drive(0, 0, 2);   chk("loss_hold", int'(sys_reset_n), 1);
    drive(0, 0, 1);   chk("loss_sysn", int'(sys_reset_n), 0);
    chk("loss_resetb", int'(pll_resetb), 0);
    chk("loss_count", int'(lock_lost_count), 1);

    // glitchy lock
    drive(0, 0, 8);
    drive(1, 0, 5);
    drive(0, 0, 1);
    drive(1, 0, 10);  chk("glitch_before_release", int'(sys_reset_n), 0);
    drive(1, 0, 1);   chk("glitch_release", int'(sys_reset_n), 1);

    // timeouts to fault, then restart
    drive(0, 0, 3);   chk("to_retry0", int'(retry_count), 0);
    drive(0, 0, 24);  chk("to_retry1", int'(retry_count), 1);
    drive(0, 0, 24);  chk("to_retry2", int'(retry_count), 2);
    drive(0, 0, 23);  chk("to_not_fault", int'(fault), 0);
    drive(0, 0, 1);   chk("to_fault", int'(fault), 1);
    chk("to_fault_resetb", int'(pll_resetb), 0);
    drive(0, 0, 30);  chk("to_fault_held", int'(fault), 1);
    drive(0, 1, 1);   chk("restart_clears_fault", int'(fault), 0);
    chk("restart_retry", int'(retry_count), 0);

    // lock arriving on the exact timeout cycle
    drive(0, 0, 21);
    drive(1, 0, 3);   chk("edge_lock_resetb", int'(pll_resetb), 1);
    chk("edge_lock_retry", int'(retry_count), 0);
    drive(1, 0, 8);   chk("edge_lock_run", int'(ready), 1);

    // restart coinciding with a timeout
    drive(0, 0, 3);
    drive(0, 0, 47);  chk("rs_to_before", int'(retry_count), 1);
    drive(0, 1, 1);   chk("rs_to_retry", int'(retry_count), 0);
    chk("rs_to_resetb", int'(pll_resetb), 0);
    drive(0, 0, 4);   chk("rs_to_fresh_reset", int'(pll_resetb), 1);

    // async reset mid-STABLE
    drive(1, 0, 6);
    do_reset(3);
    drive(1, 0, 20);  chk("after_rst_ready", int'(ready), 1);

    // lock-loss counter saturation
    for (int i = 0; i < 300; i++) begin
      drive(0, 0, 3);
      drive(1, 0, 14);
    end
    chk("lost_saturated", int'(lock_lost_count), 255);
    chk("sat_ready", int'(ready), 1);

    // async reset mid-RUN
    do_reset(2);

    // random traffic
    for (int s = 0; s < 150; s++) begin
      lk = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 25));
      for (int k = 0; k < len; k++) drive(lk, ($urandom_range(0, 59) == 0), 1);
      if ($urandom_range(0, 49) == 0) do_reset(2);
    end

    drive(1, 0, 30);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
